// File: rtl/cpu_params_pkg.sv
// Shared CPU parameters and the write-back buffer entry type.
package cpu_params_pkg;

  localparam int MAX_GPR = 16;
  localparam int RSZ     = 32;
  localparam int GPR_ASZ = $clog2(MAX_GPR);

  // valid means live: cleared when the entry drains or is squashed by a newer pipe write
  typedef struct packed {
    logic               valid;
    logic [GPR_ASZ-1:0] addr;
    logic [RSZ-1:0]     data;
  } wb_entry_t;

  function automatic logic [MAX_GPR-1:0] gpr_onehot(input logic [GPR_ASZ-1:0] a);
    return MAX_GPR'(1) << a;
  endfunction

endpackage

// File: rtl/rbus_intf.sv
// Single register-file write port.
interface RBUS_intf ();

  logic                                Rd_wr;
  logic [cpu_params_pkg::GPR_ASZ-1:0]  Rd_addr;
  logic [cpu_params_pkg::RSZ-1:0]      Rd_data;

  modport master (output Rd_wr, Rd_addr, Rd_data);
  modport slave  (input  Rd_wr, Rd_addr, Rd_data);

endinterface

// File: rtl/wb_buf.sv
// In-order buffer of long-latency results awaiting the register-file write port.
module wb_buf
  import cpu_params_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               enq,
  input  logic [GPR_ASZ-1:0] enq_addr,
  input  logic [RSZ-1:0]     enq_data,
  input  logic               deq,
  input  logic               squash,
  input  logic [GPR_ASZ-1:0] squash_addr,
  output wb_entry_t          head,
  output logic [CW-1:0]      cnt,
  output logic [MAX_GPR-1:0] pend_mask
);

  wb_entry_t       ent [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Squash runs before the tail write so an entry enqueued this cycle stays live.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash && ent[i].valid && (ent[i].addr == squash_addr))
          ent[i].valid <= 1'b0;
      end
      if (deq) begin
        ent[rd_ptr].valid <= 1'b0;
        rd_ptr            <= ptr_inc(rd_ptr);
      end
      if (enq) begin
        ent[wr_ptr] <= '{valid: 1'b1, addr: enq_addr, data: enq_data};
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head = ent[rd_ptr];

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent[i].valid) pend_mask = pend_mask | gpr_onehot(ent[i].addr);
    end
    pend_mask[0] = 1'b0;
  end

endmodule

// File: rtl/gpr_wr_arb.sv
// Arbitrates the single GPR write port between the unstallable pipe result and buffered long-latency results.
module gpr_wr_arb
  import cpu_params_pkg::*;
#(
  parameter  int BUF_DEPTH = 2,
  localparam int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               pipe_wr,
  input  logic [GPR_ASZ-1:0] pipe_addr,
  input  logic [RSZ-1:0]     pipe_data,
  input  logic               ll_valid,
  output logic               ll_ready,
  input  logic [GPR_ASZ-1:0] ll_addr,
  input  logic [RSZ-1:0]     ll_data,
  RBUS_intf.master           gpr_bus,
  output logic [MAX_GPR-1:0] pend_mask,
  output logic [CW-1:0]      buf_cnt
);

  logic      pipe_sel;
  logic      enq;
  logic      deq;
  wb_entry_t head;

  assign pipe_sel = pipe_wr && (pipe_addr != '0);
  assign ll_ready = buf_cnt < CW'(BUF_DEPTH);
  assign enq      = ll_valid && ll_ready && (ll_addr != '0);
  // A squashed head still pops in its slot, it just produces no write.
  assign deq      = !pipe_sel && (buf_cnt != '0);

  wb_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .enq         (enq),
    .enq_addr    (ll_addr),
    .enq_data    (ll_data),
    .deq         (deq),
    .squash      (pipe_sel),
    .squash_addr (pipe_addr),
    .head        (head),
    .cnt         (buf_cnt),
    .pend_mask   (pend_mask)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      gpr_bus.Rd_wr   <= 1'b0;
      gpr_bus.Rd_addr <= '0;
      gpr_bus.Rd_data <= '0;
    end else if (pipe_sel) begin
      gpr_bus.Rd_wr   <= 1'b1;
      gpr_bus.Rd_addr <= pipe_addr;
      gpr_bus.Rd_data <= pipe_data;
    end else if (deq && head.valid) begin
      gpr_bus.Rd_wr   <= 1'b1;
      gpr_bus.Rd_addr <= head.addr;
      gpr_bus.Rd_data <= head.data;
    end else begin
      gpr_bus.Rd_wr   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpr_wr_arb.sv
// Directed-vector bench for gpr_wr_arb at BUF_DEPTH 2 and 3.
module tb_gpr_wr_arb;
  import cpu_params_pkg::*;

  logic               clk_in = 1'b0;
  logic               reset_in;
  logic               pipe_wr, ll_valid, ll_ready;
  logic [GPR_ASZ-1:0] pipe_addr, ll_addr;
  logic [RSZ-1:0]     pipe_data, ll_data;
  logic [MAX_GPR-1:0] pend_mask;
  logic [1:0]         buf_cnt;

  logic               p3_wr, ll3_valid, ll3_ready;
  logic [GPR_ASZ-1:0] p3_addr, ll3_addr;
  logic [RSZ-1:0]     p3_data, ll3_data;
  logic [MAX_GPR-1:0] pend3;
  logic [1:0]         cnt3;

  int n_vec = 0;
  int n_bad = 0;

  RBUS_intf bus2 ();
  RBUS_intf bus3 ();

  always #5 clk_in = ~clk_in;

  gpr_wr_arb #(.BUF_DEPTH(2)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .pipe_wr(pipe_wr), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_addr(ll_addr), .ll_data(ll_data),
    .gpr_bus(bus2), .pend_mask(pend_mask), .buf_cnt(buf_cnt)
  );

  gpr_wr_arb #(.BUF_DEPTH(3)) dut3 (
    .clk_in(clk_in), .reset_in(reset_in),
    .pipe_wr(p3_wr), .pipe_addr(p3_addr), .pipe_data(p3_data),
    .ll_valid(ll3_valid), .ll_ready(ll3_ready), .ll_addr(ll3_addr), .ll_data(ll3_data),
    .gpr_bus(bus3), .pend_mask(pend3), .buf_cnt(cnt3)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pipe(input logic wr, input logic [GPR_ASZ-1:0] a, input logic [RSZ-1:0] d);
    pipe_wr = wr; pipe_addr = a; pipe_data = d;
  endtask

  task automatic ll(input logic v, input logic [GPR_ASZ-1:0] a, input logic [RSZ-1:0] d);
    ll_valid = v; ll_addr = a; ll_data = d;
  endtask

  task automatic chk_wr(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] d);
    check_val({tag, "_wr"}, 32'(bus2.Rd_wr), 32'(wr));
    check_val({tag, "_addr"}, 32'(bus2.Rd_addr), a);
    check_val({tag, "_data"}, bus2.Rd_data, d);
  endtask

  initial begin
    reset_in = 1'b1;
    pipe(1'b0, '0, '0);
    ll(1'b0, '0, '0);
    p3_wr = 1'b0; p3_addr = '0; p3_data = '0;
    ll3_valid = 1'b0; ll3_addr = '0; ll3_data = '0;
    step(); step();
    chk_wr("rst", 1'b0, 0, 0);
    check_val("rst_cnt", 32'(buf_cnt), 0);
    check_val("rst_pend", 32'(pend_mask), 0);
    reset_in = 1'b0;
    check_val("rst_ready", 32'(ll_ready), 1);

    // single pipe write, then idle keeps addr/data
    pipe(1'b1, 4'd5, 32'h1234);
    step();
    chk_wr("pipe5", 1'b1, 5, 32'h1234);
    pipe(1'b0, '0, '0);
    step();
    chk_wr("idle_hold", 1'b0, 5, 32'h1234);

    // two ll results held off by four pipe writes
    pipe(1'b1, 4'd1, 32'h11); ll(1'b1, 4'd3, 32'h33);
    step();
    chk_wr("p1", 1'b1, 1, 32'h11);
    check_val("cnt_a", 32'(buf_cnt), 1);
    check_val("ready_a", 32'(ll_ready), 1);
    pipe(1'b1, 4'd2, 32'h22); ll(1'b1, 4'd4, 32'h44);
    step();
    ll(1'b0, '0, '0);
    check_val("cnt_full", 32'(buf_cnt), 2);
    check_val("ready_full", 32'(ll_ready), 0);
    check_val("pend_34", 32'(pend_mask), 32'h18);
    pipe(1'b1, 4'd1, 32'h55);
    step();
    chk_wr("p3", 1'b1, 1, 32'h55);
    pipe(1'b1, 4'd2, 32'h66);
    step();
    chk_wr("p4", 1'b1, 2, 32'h66);
    pipe(1'b0, '0, '0);
    step();
    chk_wr("drain3", 1'b1, 3, 32'h33);
    check_val("pend_4", 32'(pend_mask), 32'h10);
    step();
    chk_wr("drain4", 1'b1, 4, 32'h44);
    step();
    chk_wr("drained", 1'b0, 4, 32'h44);
    check_val("pend_empty", 32'(pend_mask), 0);

    // buffered write to r7 squashed by a later pipe write to r7
    ll(1'b1, 4'd7, 32'hA);
    step();
    ll(1'b0, '0, '0);
    check_val("pend_7", 32'(pend_mask), 32'h80);
    pipe(1'b1, 4'd7, 32'hB);
    step();
    chk_wr("sq_pipe", 1'b1, 7, 32'hB);
    check_val("sq_cnt", 32'(buf_cnt), 1);
    check_val("sq_pend", 32'(pend_mask), 0);
    pipe(1'b0, '0, '0);
    step();
    chk_wr("sq_pop", 1'b0, 7, 32'hB);
    check_val("sq_cnt0", 32'(buf_cnt), 0);
    step();
    check_val("sq_nowr", 32'(bus2.Rd_wr), 0);

    // enqueue for r6 in the same cycle as a pipe write to r6 survives
    pipe(1'b1, 4'd6, 32'h61); ll(1'b1, 4'd6, 32'h62);
    step();
    pipe(1'b0, '0, '0); ll(1'b0, '0, '0);
    chk_wr("same_pipe", 1'b1, 6, 32'h61);
    check_val("same_pend", 32'(pend_mask), 32'h40);
    step();
    chk_wr("same_ll", 1'b1, 6, 32'h62);

    // register 0 on either source never writes; r0 pipe lets head drain
    ll(1'b1, 4'd0, 32'h99);
    check_val("r0_ready", 32'(ll_ready), 1);
    step();
    ll(1'b0, '0, '0);
    check_val("r0_cnt", 32'(buf_cnt), 0);
    check_val("r0_pend", 32'(pend_mask), 0);
    step();
    check_val("r0_ll_nowr", 32'(bus2.Rd_wr), 0);
    pipe(1'b1, 4'd0, 32'h77);
    step();
    chk_wr("r0_pipe", 1'b0, 6, 32'h62);
    ll(1'b1, 4'd9, 32'h90);
    pipe(1'b0, '0, '0);
    step();
    ll(1'b0, '0, '0);
    pipe(1'b1, 4'd0, 32'h78);
    step();
    pipe(1'b0, '0, '0);
    chk_wr("r0_drain", 1'b1, 9, 32'h90);
    check_val("r0_drain_cnt", 32'(buf_cnt), 0);

    // reset with a full buffer discards both entries
    pipe(1'b1, 4'd1, 32'h1); ll(1'b1, 4'd10, 32'hA0);
    step();
    ll(1'b1, 4'd11, 32'hB0);
    step();
    check_val("pre_rst_cnt", 32'(buf_cnt), 2);
    reset_in = 1'b1;
    pipe(1'b0, '0, '0); ll(1'b0, '0, '0);
    step();
    reset_in = 1'b0;
    chk_wr("mid_rst", 1'b0, 0, 0);
    check_val("mid_rst_cnt", 32'(buf_cnt), 0);
    check_val("mid_rst_pend", 32'(pend_mask), 0);
    check_val("mid_rst_ready", 32'(ll_ready), 1);
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("post_rst_nowr", 32'(bus2.Rd_wr), 0);
    end

    // depth 3: ten back-to-back ll results, pipe idle
    for (int k = 0; k < 12; k++) begin
      if (k < 10) begin
        ll3_valid = 1'b1; ll3_addr = 4'(k + 1); ll3_data = 32'h100 + 32'(k);
        check_val("d3_ready", 32'(ll3_ready), 1);
      end else begin
        ll3_valid = 1'b0; ll3_addr = '0; ll3_data = '0;
      end
      step();
      if (k >= 1 && k <= 10) begin
        check_val("d3_wr", 32'(bus3.Rd_wr), 1);
        check_val("d3_addr", 32'(bus3.Rd_addr), 32'(k));
        check_val("d3_data", bus3.Rd_data, 32'h100 + 32'(k - 1));
      end else begin
        check_val("d3_idle", 32'(bus3.Rd_wr), 0);
      end
    end
    check_val("d3_cnt", 32'(cnt3), 0);
    check_val("d3_pend", 32'(pend3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gpr_wr_arb.md
GPR_WR_ARB -- requirements
Module: gpr_wr_arb

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 2, meaning the number of long-latency result buffer entries (legal values 2..8).
REQ-002 SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_in, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port pipe_wr, input, 1 bit: a write-back-stage result is present this cycle (cannot be stalled).
REQ-005 SHALL have port pipe_addr, input, GPR_ASZ bits: destination register of the pipe result.
REQ-006 SHALL have port pipe_data, input, RSZ bits: data of the pipe result.
REQ-007 SHALL have port ll_valid, input, 1 bit: a long-latency (load/divide) result is offered.
REQ-008 SHALL have port ll_ready, output, 1 bit: the buffer can accept a long-latency result.
REQ-009 SHALL have port ll_addr, input, GPR_ASZ bits: destination register of the long-latency result.
REQ-010 SHALL have port ll_data, input, RSZ bits: data of the long-latency result.
REQ-011 SHALL have port gpr_bus, RBUS_intf.master, Rd_wr/Rd_addr/Rd_data: the single register-file write port.
REQ-012 SHALL have port pend_mask, output, MAX_GPR bits: bit k set while a live buffered write targets register k.
REQ-013 SHALL have port buf_cnt, output, $clog2(BUF_DEPTH+1) bits: occupied buffer entries, counting squashed entries.

Function
REQ-014 SHALL register all gpr_bus outputs, so an issued write appears on Rd_wr/Rd_addr/Rd_data one cycle after selection.
REQ-015 SHALL issue at most one register-file write per cycle.
REQ-016 SHALL use this priority each cycle: pipe_wr with nonzero pipe_addr first, then the buffer head, otherwise idle (Rd_wr=0).
REQ-017 SHALL drive ll_ready = (buf_cnt < BUF_DEPTH) from registered state only; ll_ready SHALL NOT depend on same-cycle dequeue.
REQ-018 SHALL accept a long-latency result when ll_valid & ll_ready and enqueue it at the tail; it SHALL never bypass the buffer, so its earliest write is two cycles after acceptance.
REQ-019 SHALL complete the handshake for ll_addr=0 but not enqueue it; pipe_wr with pipe_addr=0 SHALL produce no write and SHALL let the buffer head drain that cycle.
REQ-020 SHALL, when a pipe write to register X is selected, squash every live entry for X present at the start of that cycle; an entry for X enqueued in the same cycle SHALL stay live.
REQ-021 SHALL pop a squashed head entry, in a cycle the head would otherwise drain, without asserting Rd_wr.
REQ-022 SHALL support simultaneous enqueue and dequeue in one cycle with buf_cnt unchanged; pointers SHALL wrap modulo BUF_DEPTH.
REQ-023 SHALL hold pend_mask[0] at 0 and update pend_mask from registered entry state, reflecting enqueue, squash and dequeue one cycle later.
REQ-024 SHALL keep Rd_addr/Rd_data at their previous values when Rd_wr=0.

Reset
REQ-025 SHALL, on reset_in=1 at a clock edge, set Rd_wr=0, Rd_addr=0, Rd_data=0, buf_cnt=0, pend_mask=0 and both pointers to 0.
REQ-026 SHALL discard buffered entries when reset occurs mid-operation; ll_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-027 SHALL take MAX_GPR and RSZ from cpu_params_pkg and add GPR_ASZ = $clog2(MAX_GPR) there.
REQ-028 SHALL place the buffer-entry struct (valid, addr, data) in cpu_params_pkg.
REQ-029 SHALL implement the buffer as one sub-module, wb_buf, that owns the entries, pointers, count and squash compare.

Verification
REQ-030 SHALL cover: pipe_wr=1, addr=5, data=0x1234 -> next cycle Rd_wr=1, Rd_addr=5, Rd_data=0x1234.
REQ-031 SHALL cover: two ll results (addr 3, 4) accepted while pipe_wr=1 for 4 cycles -> ll_ready=0 at buf_cnt=2; writes to 3 then 4 on the 2 cycles after pipe_wr drops.
REQ-032 SHALL cover: ll addr 7 data 0xA buffered, then pipe_wr addr 7 data 0xB -> Rd_data=0xB written, no later write of 0xA, pend_mask[7] cleared.
REQ-033 SHALL cover: ll_valid with ll_addr=0 -> handshake completes, buf_cnt stays 0, no Rd_wr; pipe_wr addr 0 -> no Rd_wr.
REQ-034 SHALL cover: full buffer and reset_in pulsed for 1 cycle -> buf_cnt=0, pend_mask=0, ll_ready=1, no buffered write ever issued.
REQ-035 SHALL cover: BUF_DEPTH=3 with 10 back-to-back ll results and pipe idle -> all 10 written in order, pointers wrapping.
